// File: rtl/mult_div_if.sv
// mult_div_if: request/result bundle between the execute stage and the
// iterative multiply/divide unit. The execute stage is the master and
// drives the request side. The unit is the slave and drives the status
// and result side.
interface mult_div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             dz;

  modport master (
    output start, alu_ctrl, op_a, op_b,
    input  busy, done, hi, lo, dz
  );

  modport slave (
    input  start, alu_ctrl, op_a, op_b,
    output busy, done, hi, lo, dz
  );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed multiply/divide writing HI/LO.
// Multiply is radix-2 shift-add and divide is restoring division. Each
// retires one bit per cycle on operand magnitudes, and the signs are
// applied in a separate FIX cycle.
// Optional feature macro: MULDIV_DIV_EN. When defined, signed divide
// (alu_ctrl 4'b1011) is supported. When undefined, the divider datapath
// is absent, 4'b1011 is ignored and dz is tied low.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  mult_div_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);
  localparam logic [3:0] OP_MUL = 4'b0101;
`ifdef MULDIV_DIV_EN
  localparam logic [3:0] OP_DIV = 4'b1011;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef MULDIV_DIV_EN
  logic               is_div_q, is_div_d;
  logic               a_neg_q, a_neg_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic               dz_q, dz_d;
`endif

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_upper;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] prod_fix;

  // Operand magnitudes. INT_MIN wraps to 2^(WIDTH-1), which is the correct
  // unsigned magnitude.
  assign abs_a = bus.op_a[WIDTH-1] ? (~bus.op_a + 1'b1) : bus.op_a;
  assign abs_b = bus.op_b[WIDTH-1] ? (~bus.op_b + 1'b1) : bus.op_b;

  // Shift-add step. The upper half carries one extra bit, so the carry
  // shifts down into the accumulator together with the multiplier bits.
  assign mul_upper = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign mul_next  = {mul_upper, acc_q[WIDTH-1:1]};
  assign prod_fix  = neg_q ? (~acc_q + 1'b1) : acc_q;

`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]     div_shift, div_diff;
  logic               div_fits;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Restoring step. The upper half holds the partial remainder and the
  // lower half shifts the dividend out while the quotient bits shift in.
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_fits  = (div_shift >= {1'b0, opnd_q});
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_next  = {(div_fits ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                      acc_q[WIDTH-2:0], div_fits};
  assign quo_fix   = neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
  assign rem_fix   = a_neg_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1)
                             : acc_q[2*WIDTH-1:WIDTH];
`endif

  // Next state, datapath updates and registered status for the sequencer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
`ifdef MULDIV_DIV_EN
    is_div_d = is_div_q;
    a_neg_d  = a_neg_q;
    opa_d    = opa_q;
    dz_d     = dz_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.start && (bus.alu_ctrl == OP_MUL)) begin
          opnd_d   = abs_a;
          acc_d    = {{WIDTH{1'b0}}, abs_b};
          neg_d    = bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1];
          cnt_d    = '0;
          state_d  = CALC;
`ifdef MULDIV_DIV_EN
          is_div_d = 1'b0;
          dz_d     = 1'b0;
`endif
        end
`ifdef MULDIV_DIV_EN
        else if (bus.start && (bus.alu_ctrl == OP_DIV)) begin
          opnd_d   = abs_b;
          acc_d    = {{WIDTH{1'b0}}, abs_a};
          neg_d    = bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1];
          a_neg_d  = bus.op_a[WIDTH-1];
          opa_d    = bus.op_a;
          is_div_d = 1'b1;
          cnt_d    = '0;
          if (bus.op_b == '0) begin
            dz_d    = 1'b1;
            state_d = FIX;
          end else begin
            dz_d    = 1'b0;
            state_d = CALC;
          end
        end
`endif
      end

      CALC: begin
`ifdef MULDIV_DIV_EN
        acc_d = is_div_q ? div_next : mul_next;
`else
        acc_d = mul_next;
`endif
        if (cnt_q == LAST_ITER) begin
          cnt_d   = '0;
          state_d = FIX;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      FIX: begin
`ifdef MULDIV_DIV_EN
        if (is_div_q && dz_q) begin
          hi_d = opa_q;
          lo_d = '1;
        end else if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
`else
        hi_d = prod_fix[2*WIDTH-1:WIDTH];
        lo_d = prod_fix[WIDTH-1:0];
`endif
        state_d = DONE;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == CALC) || (state_d == FIX);
    done_d = (state_d == DONE);
  end

  // State register with asynchronous abort to the idle reset values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Datapath and result registers. A reset clears any partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
`ifdef MULDIV_DIV_EN
      is_div_q <= 1'b0;
      a_neg_q  <= 1'b0;
      opa_q    <= '0;
      dz_q     <= 1'b0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
`ifdef MULDIV_DIV_EN
      is_div_q <= is_div_d;
      a_neg_q  <= a_neg_d;
      opa_q    <= opa_d;
      dz_q     <= dz_d;
`endif
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
`ifdef MULDIV_DIV_EN
  assign bus.dz   = dz_q;
`else
  assign bus.dz   = 1'b0;
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: self-checking bench for mult_div_unit.
// The bench combines directed vectors, hand-built sequences for the
// multi-cycle corner cases, and random operations. Expected values come
// from a plain signed-arithmetic reference model.
module tb_mult_div_unit;

  localparam int WIDTH = 32;
  localparam logic [3:0] OP_MUL = 4'b0101;
  localparam logic [3:0] OP_DIV = 4'b1011;

  typedef struct {
    string       name;
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
    logic        expDz;
    int          expLat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mult_div_if #(.WIDTH(WIDTH)) md();

  mult_div_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (md)
  );

  int          nTests = 0;
  int          nFail  = 0;
  int          gotLat;
  logic        gotDone;
  logic        busyHeld;
  logic        busyAtDone;
  logic [31:0] gotHi, gotLo;
  logic        gotDz;
  logic [31:0] lastHi, lastLo;
  vec_t        vecs[$];

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model written directly from signed-arithmetic semantics.
  function automatic void refModel(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] h, output logic [31:0] l,
                                   output logic dz, output int lat);
    longint p;
    int     sa, sb, q, r;
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    dz  = 1'b0;
    lat = WIDTH + 1;
    if (ctrl == OP_MUL) begin
      p = longint'(sa) * longint'(sb);
      h = p[63:32];
      l = p[31:0];
    end else if (sb == 0) begin
      h   = a;
      l   = 32'hFFFF_FFFF;
      dz  = 1'b1;
      lat = 1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      h = 32'h0;
      l = 32'h8000_0000;
    end else begin
      q = sa / sb;
      r = sa % sb;
      h = r;
      l = q;
    end
  endfunction

  // Issue one accepted operation and wait, within a cycle budget, for done.
  // Optionally fire a second start partway through the operation.
  task automatic applyStimulus(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                               input int glitchAt, input logic [31:0] ga, input logic [31:0] gb);
    @(negedge clk);
    md.start    = 1'b1;
    md.alu_ctrl = ctrl;
    md.op_a     = a;
    md.op_b     = b;
    @(posedge clk);
    #1;
    md.start = 1'b0;
    md.op_a  = $urandom;
    md.op_b  = $urandom;
    gotDone  = 1'b0;
    gotLat   = 0;
    busyHeld = md.busy;
    for (int i = 1; i <= 100; i++) begin
      if (i == glitchAt) begin
        md.start    = 1'b1;
        md.alu_ctrl = OP_MUL;
        md.op_a     = ga;
        md.op_b     = gb;
      end
      @(posedge clk);
      #1;
      md.start = 1'b0;
      if (md.done) begin
        gotDone = 1'b1;
        gotLat  = i;
        break;
      end
      if (!md.busy) busyHeld = 1'b0;
    end
    busyAtDone = md.busy;
    gotHi      = md.hi;
    gotLo      = md.lo;
    gotDz      = md.dz;
  endtask

  // Compare the captured result against the expected values, then confirm
  // that done is a single-cycle pulse.
  task automatic checkOutput(input string name, input logic [31:0] expHi, input logic [31:0] expLo,
                             input logic expDz, input int expLat);
    checkVal($sformatf("%s done-seen", name), 32'(gotDone), 32'd1);
    checkVal($sformatf("%s latency", name), gotLat, expLat);
    checkVal($sformatf("%s hi", name), gotHi, expHi);
    checkVal($sformatf("%s lo", name), gotLo, expLo);
    checkVal($sformatf("%s dz", name), 32'(gotDz), 32'(expDz));
    checkVal($sformatf("%s busy-held", name), 32'(busyHeld), 32'd1);
    checkVal($sformatf("%s busy-at-done", name), 32'(busyAtDone), 32'd0);
    @(posedge clk);
    #1;
    checkVal($sformatf("%s done-pulse", name), 32'(md.done), 32'd0);
    lastHi = expHi;
    lastLo = expLo;
  endtask

  // Start with a code that must be ignored: no busy, no done, HI/LO held.
  task automatic checkIgnored(input string name, input logic [3:0] ctrl);
    logic sawBusy, sawDone;
    sawBusy = 1'b0;
    sawDone = 1'b0;
    @(negedge clk);
    md.start    = 1'b1;
    md.alu_ctrl = ctrl;
    md.op_a     = 32'd3;
    md.op_b     = 32'd4;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      md.start = 1'b0;
      if (md.busy) sawBusy = 1'b1;
      if (md.done) sawDone = 1'b1;
    end
    checkVal($sformatf("%s busy", name), 32'(sawBusy), 32'd0);
    checkVal($sformatf("%s done", name), 32'(sawDone), 32'd0);
    checkVal($sformatf("%s hi", name), md.hi, lastHi);
    checkVal($sformatf("%s lo", name), md.lo, lastLo);
  endtask

  function automatic logic [31:0] pickOperand();
    logic [31:0] v;
    case ($urandom_range(0, 6))
      0:       v = 32'h8000_0000;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'($urandom_range(0, 20));
      3:       v = 32'h7FFF_FFFF;
      4:       v = 32'h0;
      default: v = 32'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    logic [31:0] eh, el;
    logic        ed;
    int          elat;
    logic [3:0]  rc;
    logic [31:0] ra, rb;
    int          sawDone;

    rst_n       = 1'b0;
    md.start    = 1'b0;
    md.alu_ctrl = 4'b0000;
    md.op_a     = '0;
    md.op_b     = '0;
    lastHi      = '0;
    lastLo      = '0;

    vecs.push_back('{"mul 7x-3",      OP_MUL, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33});
    vecs.push_back('{"mul min*min",   OP_MUL, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 33});
    vecs.push_back('{"mul -1*-1",     OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 33});
    vecs.push_back('{"mul max*max",   OP_MUL, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0, 33});
    vecs.push_back('{"mul min*-1",    OP_MUL, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 33});
    vecs.push_back('{"mul min*1",     OP_MUL, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 33});
`ifdef MULDIV_DIV_EN
    vecs.push_back('{"div -7/2",      OP_DIV, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33});
    vecs.push_back('{"div min/-1",    OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 33});
    vecs.push_back('{"div 100/-7",    OP_DIV, 32'd100,        32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2, 1'b0, 33});
    vecs.push_back('{"div 5/0",       OP_DIV, 32'd5,          32'd0,          32'h0000_0005, 32'hFFFF_FFFF, 1'b1, 1});
`endif

    repeat (3) @(posedge clk);
    #1;
    checkVal("reset busy", 32'(md.busy), 32'd0);
    checkVal("reset done", 32'(md.done), 32'd0);
    checkVal("reset hi", md.hi, 32'h0);
    checkVal("reset lo", md.lo, 32'h0);
    checkVal("reset dz", 32'(md.dz), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].ctrl, vecs[i].a, vecs[i].b, 0, 32'h0, 32'h0);
      checkOutput(vecs[i].name, vecs[i].expHi, vecs[i].expLo, vecs[i].expDz, vecs[i].expLat);
    end

`ifdef MULDIV_DIV_EN
    // dz was left set by the zero divide; the next accepted start clears it.
    @(negedge clk);
    md.start    = 1'b1;
    md.alu_ctrl = OP_MUL;
    md.op_a     = 32'd3;
    md.op_b     = 32'd3;
    @(posedge clk);
    #1;
    md.start = 1'b0;
    checkVal("dz cleared on start", 32'(md.dz), 32'd0);
    sawDone = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (md.done) begin
        sawDone = 1;
        break;
      end
    end
    checkVal("dz-clear op done-seen", sawDone, 1);
    lastHi = 32'h0;
    lastLo = 32'd9;
    @(posedge clk);
    #1;
`else
    checkIgnored("div code ignored", OP_DIV);
`endif

    checkIgnored("code 0010 ignored", 4'b0010);

    applyStimulus(OP_MUL, 32'd7, 32'hFFFF_FFFD, 6, 32'd2, 32'd2);
    checkOutput("start during calc", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33);

    for (int n = 0; n < 40; n++) begin
`ifdef MULDIV_DIV_EN
      rc = ($urandom_range(0, 1) == 0) ? OP_MUL : OP_DIV;
`else
      rc = OP_MUL;
`endif
      ra = pickOperand();
      rb = pickOperand();
      refModel(rc, ra, rb, eh, el, ed, elat);
      applyStimulus(rc, ra, rb, 0, 32'h0, 32'h0);
      checkOutput($sformatf("rand%0d %h %h %h", n, rc, ra, rb), eh, el, ed, elat);
    end

    // Load a known nonzero result, then abort a multiply at iteration 10.
    applyStimulus(OP_MUL, 32'd7, 32'hFFFF_FFFD, 0, 32'h0, 32'h0);
    checkOutput("pre-reset mul", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33);
    @(negedge clk);
    md.start    = 1'b1;
    md.alu_ctrl = OP_MUL;
    md.op_a     = 32'd12345;
    md.op_b     = 32'hFFFF_0000;
    @(posedge clk);
    #1;
    md.start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkVal("abort busy", 32'(md.busy), 32'd0);
    checkVal("abort done", 32'(md.done), 32'd0);
    checkVal("abort hi", md.hi, 32'h0);
    checkVal("abort lo", md.lo, 32'h0);
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    sawDone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (md.done) sawDone = 1;
    end
    checkVal("abort no done", sawDone, 0);
    checkVal("abort idle busy", 32'(md.busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
